// File: rtl/mac_stream_driver.sv
// Feeder/collector for the MAC+ReLU neuron: holds X/W vectors, streams
// len pairs to the neuron, waits out its latency, offers the result.
//
// Ports:
//   clk, rst (async active-low)
//   wr_en/wr_addr/wr_x/wr_w : register-file write port (idle only)
//   start/len               : launch a pass of len terms (1..DEPTH)
//   busy                    : high outside IDLE
//   mac_clear/mac_enable    : accumulator control to the neuron
//   x_out/w_out             : operand pair to the neuron
//   result_in               : neuron output
//   result/result_valid/result_ready : captured result handshake
module mac_stream_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_x,
  input  logic signed [WIDTH-1:0] wr_w,
  input  logic                    start,
  input  logic [AW:0]             len,
  output logic                    busy,
  output logic                    mac_clear,
  output logic                    mac_enable,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] w_out,
  input  logic signed [WIDTH-1:0] result_in,
  output logic signed [WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam int LW = AW + 1;
  localparam int CW = $clog2(LAT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]             state;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic signed [WIDTH-1:0] xm [DEPTH];
  logic signed [WIDTH-1:0] wm [DEPTH];

  logic wr_ok;
  logic len_ok;

  assign wr_ok  = ({1'b0, wr_addr} < LW'(DEPTH));
  assign len_ok = (len != '0) && (len <= LW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len_q        <= '0;
      idx          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      mac_clear    <= 1'b0;
      mac_enable   <= 1'b0;
      x_out        <= '0;
      w_out        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        xm[i] <= '0;
        wm[i] <= '0;
      end
    end else begin
      if (wr_en && !busy && wr_ok) begin
        xm[wr_addr] <= wr_x;
        wm[wr_addr] <= wr_w;
      end
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state     <= CLEAR;
            len_q     <= len;
            idx       <= '0;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
          end
        end
        CLEAR: begin
          // outputs for term 0 are staged here so streaming has no gap
          state      <= STREAM;
          mac_clear  <= 1'b0;
          mac_enable <= 1'b1;
          x_out      <= xm[0];
          w_out      <= wm[0];
          idx        <= LW'(1);
        end
        STREAM: begin
          if (idx == len_q) begin
            state      <= DRAIN;
            mac_enable <= 1'b0;
            x_out      <= '0;
            w_out      <= '0;
            cnt        <= CW'(LAT);
          end else begin
            x_out <= xm[idx[AW-1:0]];
            w_out <= wm[idx[AW-1:0]];
            idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == CW'(1)) begin
            state        <= HOLD;
            result       <= result_in;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          mac_clear    <= 1'b0;
          mac_enable   <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a small neuron model
// (accumulate, then one ReLU/saturate register stage -> LAT=2).
module tb_mac_stream_driver;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic signed [7:0] wr_x;
  logic signed [7:0] wr_w;
  logic              start;
  logic [4:0]        len;
  logic              busy;
  logic              mac_clear;
  logic              mac_enable;
  logic signed [7:0] x_out;
  logic signed [7:0] w_out;
  logic signed [7:0] result_in;
  logic signed [7:0] result;
  logic              result_valid;
  logic              result_ready;

  int n_chk;
  int n_fail;

  int                acc;
  logic signed [7:0] rin;
  logic              ovr;
  logic signed [7:0] ovr_val;

  mac_stream_driver #(
    .WIDTH(8), .DEPTH(16), .AW(4), .LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_x(wr_x),
    .wr_w(wr_w),
    .start(start),
    .len(len),
    .busy(busy),
    .mac_clear(mac_clear),
    .mac_enable(mac_enable),
    .x_out(x_out),
    .w_out(w_out),
    .result_in(result_in),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mac_clear)
      acc <= 0;
    else if (mac_enable)
      acc <= acc + int'(x_out) * int'(w_out);
    if (acc < 0)
      rin <= 8'sd0;
    else if (acc > 127)
      rin <= 8'sd127;
    else
      rin <= 8'(acc);
  end

  assign result_in = ovr ? ovr_val : rin;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int x, input int w);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_x    = 8'(x);
    wr_w    = 8'(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    len   = 5'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, int'(result_valid), 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  int e_clr [7] = '{1, 0, 0, 0, 0, 0, 0};
  int e_en  [7] = '{0, 1, 1, 1, 0, 0, 0};
  int e_x   [7] = '{0, 1, 2, 3, 0, 0, 0};
  int e_w   [7] = '{0, 4, 5, 6, 0, 0, 0};
  int e_v   [7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    n_chk = 0;
    n_fail = 0;
    acc = 0;
    rin = '0;
    ovr = 1'b0;
    ovr_val = '0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_x = '0;
    wr_w = '0;
    start = 1'b0;
    len = '0;
    result_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_en", int'(mac_enable), 0);
    rst = 1'b1;
    tick();

    // basic pass: (1,4),(2,5),(3,6) -> 32
    wr(0, 1, 4);
    wr(1, 2, 5);
    wr(2, 3, 6);
    go(3);
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("p1_clr%0d", c + 1), int'(mac_clear), e_clr[c]);
      chk($sformatf("p1_en%0d", c + 1), int'(mac_enable), e_en[c]);
      chk($sformatf("p1_x%0d", c + 1), int'(x_out), e_x[c]);
      chk($sformatf("p1_w%0d", c + 1), int'(w_out), e_w[c]);
      chk($sformatf("p1_v%0d", c + 1), int'(result_valid), e_v[c]);
      chk($sformatf("p1_busy%0d", c + 1), int'(busy), 1);
      if (c < 6) tick();
    end
    chk("p1_result", int'(result), 32);

    // backpressure, then handshake with a stray start
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_valid", int'(result_valid), 1);
      chk("hold_result", int'(result), 32);
    end
    result_ready = 1'b1;
    start = 1'b1;
    len = 5'd3;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", int'(result_valid), 0);
    chk("hs_busy", int'(busy), 0);
    chk("hs_result", int'(result), 32);
    tick();
    chk("hs_start_busy", int'(busy), 0);
    chk("hs_start_clr", int'(mac_clear), 0);

    // illegal lengths
    go(0);
    chk("len0_busy", int'(busy), 0);
    chk("len0_clr", int'(mac_clear), 0);
    go(17);
    chk("len17_busy", int'(busy), 0);
    chk("len17_clr", int'(mac_clear), 0);
    tick();
    chk("len17_busy2", int'(busy), 0);

    // busy write and stray start are dropped
    wr(3, 10, 1);
    go(4);
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_x = 8'sd9;
    wr_w = 8'sd9;
    start = 1'b1;
    len = 5'd2;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("p2_x0", int'(x_out), 1);
    chk("p2_w0", int'(w_out), 4);
    tick();
    chk("p2_x1", int'(x_out), 2);
    chk("p2_clr1", int'(mac_clear), 0);
    tick();
    chk("p2_x2", int'(x_out), 3);
    tick();
    chk("p2_x3", int'(x_out), 10);
    chk("p2_w3", int'(w_out), 1);
    tick();
    chk("p2_en_off", int'(mac_enable), 0);
    wait_valid("p2_valid");
    chk("p2_result", int'(result), 42);
    accept();
    go(1);
    tick();
    chk("p3_x0", int'(x_out), 1);
    chk("p3_w0", int'(w_out), 4);
    wait_valid("p3_valid");
    chk("p3_result", int'(result), 4);
    accept();

    // signed extremes pass straight through
    wr(0, -128, -1);
    wr(1, 127, -128);
    ovr = 1'b1;
    ovr_val = -8'sd5;
    go(2);
    tick();
    chk("sx_x0", int'(x_out), -128);
    chk("sx_w0", int'(w_out), -1);
    tick();
    chk("sx_x1", int'(x_out), 127);
    chk("sx_w1", int'(w_out), -128);
    wait_valid("sx_valid");
    chk("sx_result", int'(result), -5);
    accept();
    ovr = 1'b0;

    // async reset in the second stream cycle
    wr(0, 1, 4);
    wr(1, 2, 5);
    go(2);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_en", int'(mac_enable), 0);
    chk("ar_x", int'(x_out), 0);
    chk("ar_w", int'(w_out), 0);
    chk("ar_result", int'(result), 0);
    chk("ar_valid", int'(result_valid), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_busy2", int'(busy), 0);
    go(1);
    tick();
    chk("ar_en1", int'(mac_enable), 1);
    chk("ar_x1", int'(x_out), 0);
    chk("ar_w1", int'(w_out), 0);
    wait_valid("ar_valid2");
    chk("ar_result2", int'(result), 0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_stream_driver.md
Name: mac_stream_driver

Overview:
- Feeder/collector for the MAC+ReLU neuron datapath.
- Holds an input vector X and weight vector W in local register files, loaded through a simple write port.
- On start, clears the neuron's accumulator, streams len (x, w) pairs with enable, waits out the neuron latency, then captures the neuron output and offers it on a valid/ready handshake.
- Sits between the host/control logic and the neuron instance.

Parameters:
- WIDTH, 8, data width of x, w and the neuron result.
- DEPTH, 16, maximum vector length (register-file entries).
- AW, 4, address/length width; DEPTH <= 2**AW.
- LAT, 2, neuron cycles from the last enabled pair to a valid result_in (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  register-file write strobe.
- wr_addr  in  AW  write address.
- wr_x  in  WIDTH signed  X entry data.
- wr_w  in  WIDTH signed  W entry data.
- start  in  1  start-pass pulse.
- len  in  AW+1  number of terms, 1..DEPTH.
- busy  out  1  high in any state other than IDLE.
- mac_clear  out  1  one-cycle accumulator clear to the neuron.
- mac_enable  out  1  accumulate strobe to the neuron.
- x_out  out  WIDTH signed  x to the neuron.
- w_out  out  WIDTH signed  w to the neuron.
- result_in  in  WIDTH signed  neuron output.
- result  out  WIDTH signed  captured result.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: busy, mac_clear, mac_enable, x_out, w_out, result, result_valid.
  - Index, drain counter and both register files are cleared to 0.
- Release of rst is synchronous to clk.
- Writes:
  - With wr_en=1 and busy=0, X[wr_addr]<=wr_x and W[wr_addr]<=wr_w at the clock edge.
  - Writes with busy=1 are ignored.
  - Writes with wr_addr>=DEPTH are ignored.
- All control/data outputs are registered (driven from flops, no combinational path from inputs).
- FSM states: IDLE, CLEAR, STREAM, DRAIN, HOLD.
- IDLE:
  - start=1 with 1<=len<=DEPTH: latch len, index<=0, go to CLEAR.
  - start with len==0 or len>DEPTH is ignored; the block stays in IDLE.
- CLEAR:
  - Exactly one cycle with mac_clear=1 and mac_enable=0; then go to STREAM.
- STREAM:
  - For k=0..len-1, one cycle each: mac_enable=1, x_out=X[k], w_out=W[k]. No gaps.
  - After the cycle with k=len-1, go to DRAIN with the counter loaded to LAT.
- DRAIN:
  - mac_enable=0, x_out=0, w_out=0 for LAT cycles.
  - On the last DRAIN cycle, result<=result_in and go to HOLD.
- HOLD:
  - result_valid=1 and result stays stable.
  - When result_valid & result_ready, then at that edge result_valid<=0 and the FSM goes to IDLE. result retains its value.
- Timing:
  - The first busy cycle is the cycle after start is sampled.
  - Start-to-result_valid latency is 1 + len + LAT + 1 cycles.
- start asserted while busy=1 is ignored, including a start in the same cycle as the HOLD handshake.
- result_ready while result_valid=0 has no effect.
- A reset mid-pass aborts immediately. A new pass requires reloading the register files, because reset clears them.
- No arithmetic is performed in this block; x_out, w_out and result are passed through unmodified (signed, WIDTH bits).

Test Plan:
- Load X={1,2,3}, W={4,5,6}, start with len=3, bench neuron model drives result_in=32 at LAT=2:
  - mac_clear high for 1 cycle.
  - mac_enable high for 3 consecutive cycles with (x,w)=(1,4),(2,5),(3,6).
  - result_valid rises 7 cycles after start with result=32.
- Hold result_ready=0 for 5 cycles in HOLD:
  - result_valid and result stay stable.
  - Assert ready: valid falls on the next edge and busy falls.
- start with len=0, and separately with len=17 (DEPTH=16):
  - No state change; busy stays 0; no mac_clear pulse.
- Write X[0]=9 during STREAM of a len=4 pass, and pulse start mid-pass:
  - Stream uses the original X[0].
  - The stray start is ignored.
  - A subsequent pass shows the original X[0], since the busy write was dropped.
- Load X={-128,127}, W={-1,-128}, len=2 (sign/boundary passthrough):
  - x_out/w_out show exactly -128/-1 then 127/-128.
  - result_in=-5 is captured as -5.
- Assert rst=0 asynchronously during the second STREAM cycle:
  - All outputs go to 0 within the same cycle, without waiting for a clock edge.
  - After release: busy=0 and register files read 0 (a len=1 pass streams (0,0)).
